// File: rtl/fifo_pkg.sv
// Shared sizing helpers, default configuration and threshold legality check
// for the single-clock flagged FIFO.
package fifo_pkg;

   localparam int DEF_DATAWIDTH    = 8;
   localparam int DEF_ADDR_WIDTH   = 3;
   localparam int DEF_AFULL_LEVEL  = 6;
   localparam int DEF_AEMPTY_LEVEL = 1;

   function automatic int fifo_depth(input int aw);
      return 1 << aw;
   endfunction

   // One extra pointer bit distinguishes full from empty.
   function automatic int count_width(input int aw);
      return aw + 1;
   endfunction

   function automatic bit levels_legal(input int aw, input int afull, input int aempty);
      return (afull >= 1) && (afull <= fifo_depth(aw)) &&
             (aempty >= 0) && (aempty < fifo_depth(aw));
   endfunction

endpackage

// File: rtl/sfifo_mem.sv
// Single-clock FIFO storage: one write port, read port registered by default or
// combinational (first-word-fall-through) when SYNC_FIFO_FWFT_EN is defined.
module sfifo_mem #(
   parameter int datawidth  = 8,
   parameter int addr_width = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [addr_width-1:0] waddr,
   input  logic [datawidth-1:0]  wdata,
   input  logic                  re,
   input  logic [addr_width-1:0] raddr,
   output logic [datawidth-1:0]  rdata
);

   // Contents are intentionally never reset.
   logic [datawidth-1:0] mem [1<<addr_width];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign rdata = mem[raddr];

   logic unused;
   assign unused = rst | re;
`else
   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
`endif

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost flags, sticky error flags and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read timing.
module sync_fifo_flags
   import fifo_pkg::*;
#(
   parameter int datawidth    = DEF_DATAWIDTH,
   parameter int addr_width   = DEF_ADDR_WIDTH,
   parameter int afull_level  = DEF_AFULL_LEVEL,
   parameter int aempty_level = DEF_AEMPTY_LEVEL
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [datawidth-1:0] wdata,
   input  logic                 winc,
   input  logic                 rinc,
   output logic [datawidth-1:0] rdata,
   output logic                 wfull,
   output logic                 rempty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic [addr_width:0]  count,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int DEPTH = fifo_depth(addr_width);
   localparam int CW    = count_width(addr_width);

   if (!levels_legal(addr_width, afull_level, aempty_level)) begin : g_bad_cfg
      $error("sync_fifo_flags: afull_level/aempty_level outside legal range");
   end

   logic [CW-1:0] wptr, rptr;
   logic          w_acc, r_acc;

   // Pointers wrap modulo 2*DEPTH, so the plain difference is the occupancy.
   assign count        = wptr - rptr;
   assign wfull        = (count == CW'(DEPTH));
   assign rempty       = (count == '0);
   assign almost_full  = (count >= CW'(afull_level));
   assign almost_empty = (count <= CW'(aempty_level));

   // Gating uses this cycle's flags; flush and rst suppress both ports.
   assign w_acc = winc & ~wfull  & ~flush & ~rst;
   assign r_acc = rinc & ~rempty & ~flush & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (w_acc) wptr <= wptr + 1'b1;
         if (r_acc) rptr <= rptr + 1'b1;
         if (winc & wfull)  overflow  <= 1'b1;
         if (rinc & rempty) underflow <= 1'b1;
      end
   end

   sfifo_mem #(
      .datawidth  (datawidth),
      .addr_width (addr_width)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (w_acc),
      .waddr (wptr[addr_width-1:0]),
      .wdata (wdata),
      .re    (r_acc),
      .raddr (rptr[addr_width-1:0]),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed plus randomized bench for sync_fifo_flags against a queue-based model.
module tb_sync_fifo_flags;

   logic       clk = 1'b0;
   logic       rst, flush, winc, rinc;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       wfull, rempty, almost_full, almost_empty, overflow, underflow;
   logic [3:0] count;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Behavioural model: contents as a queue, plus sticky flags and read register.
   logic [7:0] mq[$];
   bit         ovf_m, udf_m;
   logic [7:0] rd_m;

   sync_fifo_flags dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .wdata        (wdata),
      .winc         (winc),
      .rinc         (rinc),
      .rdata        (rdata),
      .wfull        (wfull),
      .rempty       (rempty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_step(input bit r, input bit f, input bit w, input bit rd,
                                      input logic [7:0] d);
      bit full, empty;
      if (r) begin
         mq.delete();
         ovf_m = 1'b0;
         udf_m = 1'b0;
         rd_m  = 8'h00;
      end else if (f) begin
         mq.delete();
      end else begin
         full  = (mq.size() == 8);
         empty = (mq.size() == 0);
         if (w && full)  ovf_m = 1'b1;
         if (rd && empty) udf_m = 1'b1;
         if (rd && !empty) rd_m = mq.pop_front();
         if (w && !full) mq.push_back(d);
      end
   endfunction

   task automatic cyc(input bit r, input bit f, input bit w, input bit rd, input logic [7:0] d);
      rst = r; flush = f; winc = w; rinc = rd; wdata = d;
      @(posedge clk);
      model_step(r, f, w, rd, d);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("count",        int'(count),        mq.size());
         chk("wfull",        int'(wfull),        int'(mq.size() == 8));
         chk("rempty",       int'(rempty),       int'(mq.size() == 0));
         chk("almost_full",  int'(almost_full),  int'(mq.size() >= 6));
         chk("almost_empty", int'(almost_empty), int'(mq.size() <= 1));
         chk("overflow",     int'(overflow),     int'(ovf_m));
         chk("underflow",    int'(underflow),    int'(udf_m));
`ifdef SYNC_FIFO_FWFT_EN
         if (mq.size() > 0) chk("rdata_fwft", int'(rdata), int'(mq[0]));
`else
         chk("rdata", int'(rdata), int'(rd_m));
`endif
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
      @(negedge clk);
      cyc(1, 0, 0, 0, 8'h00);
      chk_en = 1'b1;

      // Reset state
      chk("rst_count", int'(count), 0);
      chk("rst_rempty", int'(rempty), 1);
      chk("rst_aempty", int'(almost_empty), 1);
      chk("rst_wfull", int'(wfull), 0);
`ifndef SYNC_FIFO_FWFT_EN
      chk("rst_rdata", int'(rdata), 0);
`endif

      // 1: fill with 0x01..0x08, then drain
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 0, 1, 0, 8'(i));
         chk("t1_count", int'(count), i);
         if (i == 2) chk("t1_aempty_drop", int'(almost_empty), 0);
         if (i == 5) chk("t1_afull_low", int'(almost_full), 0);
         if (i == 6) chk("t1_afull_rise", int'(almost_full), 1);
      end
      chk("t1_wfull", int'(wfull), 1);
      for (int i = 1; i <= 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         chk("t1_rdata_fwft", int'(rdata), i);
`endif
         cyc(0, 0, 0, 1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
         chk("t1_rdata", int'(rdata), i);
`endif
      end
      chk("t1_rempty", int'(rempty), 1);

      // 2: simultaneous read/write while full
      for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 8'(8'h10 + i));
      cyc(0, 0, 1, 1, 8'hEE);
      chk("t2_count", int'(count), 7);
      chk("t2_overflow", int'(overflow), 1);
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 8'h00);
      chk("t2_overflow_sticky", int'(overflow), 1);

      // 3: simultaneous read/write while empty
      cyc(0, 0, 1, 1, 8'hA5);
      chk("t3_count", int'(count), 1);
      chk("t3_underflow", int'(underflow), 1);
`ifdef SYNC_FIFO_FWFT_EN
      chk("t3_rdata_fwft", int'(rdata), 8'hA5);
      cyc(0, 0, 0, 1, 8'h00);
`else
      cyc(0, 0, 0, 1, 8'h00);
      chk("t3_rdata", int'(rdata), 8'hA5);
`endif

      // 4: steady state at count=4 across pointer wrap
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 8'(8'h30 + i));
      for (int i = 0; i < 20; i++) begin
         cyc(0, 0, 1, 1, 8'(8'h40 + i));
         chk("t4_count", int'(count), 4);
      end

      // 5: flush with a concurrent write at count=5
      cyc(0, 0, 1, 0, 8'h77);
      chk("t5_pre_count", int'(count), 5);
      cyc(0, 1, 1, 0, 8'h99);
      chk("t5_count", int'(count), 0);
      chk("t5_rempty", int'(rempty), 1);
      chk("t5_afull", int'(almost_full), 0);
      chk("t5_overflow_hold", int'(overflow), 1);
      chk("t5_underflow_hold", int'(underflow), 1);

      // 6: reset mid-stream with a concurrent write
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 8'(8'h50 + i));
      cyc(1, 0, 1, 0, 8'h5A);
      chk("t6_count", int'(count), 0);
      chk("t6_overflow", int'(overflow), 0);
      chk("t6_underflow", int'(underflow), 0);
      chk("t6_rempty", int'(rempty), 1);
`ifndef SYNC_FIFO_FWFT_EN
      chk("t6_rdata", int'(rdata), 0);
`endif

      // Randomized traffic with occasional flush and reset
      for (int i = 0; i < 3000; i++) begin
         automatic int  p  = int'($urandom_range(0, 99));
         automatic bit  r  = (p == 0);
         automatic bit  f  = (p >= 1 && p <= 3);
         automatic int  bias = (i / 300) % 3;
         automatic bit  w  = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
         automatic bit  rd = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
         cyc(r, f, w, rd, 8'($urandom));
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
